carry_lookahead_adder_sync: RTL and testbench
=============================================

# carry_lookahead_adder_sync

Parameterised two's-complement adder with block-structured carry-lookahead logic and registered outputs. It computes A + B + Cin and reports the sum, the unsigned carry-out (CF) and the signed overflow (OF). It is a datapath leaf used by ALU and accumulator blocks that need a fast single-cycle add with flags.

## Interface
- DATA_WIDTH, 16: operand and sum width in bits; must be ≥ 2.
- BLOCK_SIZE, 1: bits per lookahead group; DATA_WIDTH must be an integer multiple of BLOCK_SIZE.

- clk  in  1  rising-edge clock; the block's single clock.
- rst  in  1  synchronous, active-high reset.
- A  in  DATA_WIDTH  operand A, unsigned or two's complement.
- B  in  DATA_WIDTH  operand B.
- Cin  in  1  carry into bit 0.
- S  out  DATA_WIDTH  registered sum, (A + B + Cin) mod 2^DATA_WIDTH.
- CF  out  1  registered carry out of the MSB.
- OF  out  1  registered signed overflow.

## Operation
- Per bit i:
  - generate g[i] = A[i] & B[i]
  - propagate p[i] = A[i] ^ B[i]
- Per group k of BLOCK_SIZE bits:
  - group generate G[k] and group propagate P[k] are formed by lookahead across the group's bits.
  - internal carries are formed by lookahead from the group carry-in c_k.
- Group carries: c_0 = Cin; c_{k+1} = G[k] | (P[k] & c_k). No bit-serial ripple is allowed inside a group.
- Sum: S[i] = p[i] ^ c[i].
- Carry flag: CF = c[DATA_WIDTH], the carry out of the MSB.
- Overflow flag: OF = c[DATA_WIDTH] ^ c[DATA_WIDTH-1]. Equivalently, A and B have the same sign and S differs from it.
- Arithmetic rules:
  - Result width is exactly DATA_WIDTH and wraps modulo 2^DATA_WIDTH.
  - CF and OF are independent; both may be set together.
- The data path has no state other than the output register.

## Timing
- Lookahead and sum logic are purely combinational from A/B/Cin to the D inputs of the output register.
- S, CF and OF are registered on the rising edge of clk.
- Latency is 1 cycle: inputs present before edge N appear on the outputs after edge N.
- Throughput is one add per cycle.
- The block has no handshake and no enable; it updates every cycle.
- Reset:
  - A rising edge with rst=1 forces S=0, CF=0 and OF=0.
  - Reset has priority over that edge's computed result.
  - The reset value of every output is 0.
  - Outputs keep their reset values until the first edge with rst=0, which loads the result of the inputs present at that edge.
  - Asserting reset mid-stream discards the in-flight result.
- An input change between edges has no effect on the outputs until the next edge.

## Structure
- Shared package: none required. Width checks (DATA_WIDTH % BLOCK_SIZE == 0, DATA_WIDTH ≥ 2) are elaboration-time assertions in the module.
- One sub-module, cla_block, parameterised by BLOCK_SIZE:
  - inputs: per-bit g/p and the group carry-in.
  - outputs: internal carries, G and P.
- The top level:
  - instantiates DATA_WIDTH/BLOCK_SIZE copies of cla_block with a generate loop.
  - chains the group carries.
  - forms S, CF and OF.
  - holds the output register.

## Test plan
Default parameters unless noted; each row checks the outputs one cycle after the inputs are applied.

- Reset: hold rst=1 for 2 cycles with A=FFFF, B=FFFF, Cin=1 -> S=0000, CF=0, OF=0. The first edge after rst falls gives S=FFFF, CF=1, OF=0.
- Carry without overflow: Cin=0, A=F077, B=7777 -> S=67EE, CF=1, OF=0. Then A=F997, B=1111 -> S=0AA8, CF=1, OF=0.
- Positive overflow: Cin=0, A=6077, B=6753 -> S=C7CA, CF=0, OF=1.
- Negative overflow with carry: Cin=0, A=8AA7, B=8111 -> S=0BB8, CF=1, OF=1.
- Carry-in propagation across the full width: A=FFFF, B=0000, Cin=1 -> S=0000, CF=1, OF=0. Then A=7FFF, B=0000, Cin=1 -> S=8000, CF=0, OF=1.
- Parameter sweep: BLOCK_SIZE ∈ {1, 2, 4, 8, 16} and DATA_WIDTH ∈ {8, 16, 32}. Back-to-back random vectors, one per cycle, plus a mid-stream reset. Compare against the 1-cycle-delayed reference A+B+Cin; the cycle after reset reads all zeros.

Source files
------------

// File: rtl/carry_lookahead_adder_sync_pkg.sv
// Shared defaults for the carry-lookahead adder and its lookahead group.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package carry_lookahead_adder_sync_pkg;

  // Default operand width and lookahead group size.
  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int DEFAULT_BLOCK_SIZE = 1;

endpackage : carry_lookahead_adder_sync_pkg

// File: rtl/carry_lookahead_adder_sync_cla_block.sv
// One carry-lookahead group: internal bit carries plus group generate/propagate.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows inputs continuously.
//
// Ports:
//   g, p      per-bit generate / propagate of this group
//   cin       carry into the group's lowest bit
//   carry     carry into each bit of the group (carry[0] == cin)
//   grp_gen   group generate (carry out of the group assuming cin = 0)
//   grp_prop  group propagate (every bit propagates)
module cla_block
  import carry_lookahead_adder_sync_pkg::*;
#(
  parameter int BLOCK_SIZE = DEFAULT_BLOCK_SIZE
) (
  input  logic [BLOCK_SIZE-1:0] g,
  input  logic [BLOCK_SIZE-1:0] p,
  input  logic                  cin,
  output logic [BLOCK_SIZE-1:0] carry,
  output logic                  grp_gen,
  output logic                  grp_prop
);

  // Carry into bit n, written as a flat sum of products:
  //   cin & p[0..n-1]  |  OR over m<n of ( g[m] & p[m+1..n-1] )
  // Every term depends only on g/p/cin, so there is no carry ripple
  // between bits of the group.
  function automatic logic lookahead(input logic [BLOCK_SIZE-1:0] gv,
                                     input logic [BLOCK_SIZE-1:0] pv,
                                     input logic                  ci,
                                     input int                    n);
    logic acc;
    logic term;
    acc = ci;
    for (int i = 0; i < n; i++) begin
      acc = acc & pv[i];
    end
    for (int m = 0; m < n; m++) begin
      term = gv[m];
      for (int i = m + 1; i < n; i++) begin
        term = term & pv[i];
      end
      acc = acc | term;
    end
    return acc;
  endfunction

  always_comb begin
    carry = '0;
    for (int j = 0; j < BLOCK_SIZE; j++) begin
      carry[j] = lookahead(g, p, cin, j);
    end
    // Group generate is the carry out of the top bit with a zero carry-in.
    grp_gen  = lookahead(g, p, 1'b0, BLOCK_SIZE);
    grp_prop = &p;
  end

endmodule : cla_block

// File: rtl/carry_lookahead_adder_sync.sv
// Registered two's-complement adder S = A + B + Cin with carry (CF) and overflow (OF) flags.
// Latency: 1 cycle, inputs before edge N are visible on S/CF/OF after edge N.
// Backpressure: none; no enable or handshake, the register loads every cycle.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset, clears S/CF/OF
//   A, B  operands (unsigned or two's complement)
//   Cin   carry into bit 0
//   S     registered sum modulo 2^DATA_WIDTH
//   CF    registered carry out of the MSB
//   OF    registered signed overflow
module carry_lookahead_adder_sync
  import carry_lookahead_adder_sync_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int BLOCK_SIZE = DEFAULT_BLOCK_SIZE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic                  Cin,
  output logic [DATA_WIDTH-1:0] S,
  output logic                  CF,
  output logic                  OF
);

  localparam int NUM_GROUPS = DATA_WIDTH / BLOCK_SIZE;

  if (DATA_WIDTH < 2) begin : g_bad_width
    $error("carry_lookahead_adder_sync: DATA_WIDTH must be at least 2");
  end
  if ((DATA_WIDTH % BLOCK_SIZE) != 0) begin : g_bad_block
    $error("carry_lookahead_adder_sync: DATA_WIDTH must be a multiple of BLOCK_SIZE");
  end

  logic [DATA_WIDTH-1:0] bit_gen;
  logic [DATA_WIDTH-1:0] bit_prop;
  logic [DATA_WIDTH-1:0] bit_carry;   // carry into each bit
  logic [NUM_GROUPS:0]   grp_carry;   // carry into each group; top entry is the MSB carry-out
  logic [NUM_GROUPS-1:0] grp_gen;
  logic [NUM_GROUPS-1:0] grp_prop;

  logic [DATA_WIDTH-1:0] sum_d;
  logic                  cf_d;
  logic                  of_d;

  assign bit_gen      = A & B;
  assign bit_prop     = A ^ B;
  assign grp_carry[0] = Cin;

  for (genvar k = 0; k < NUM_GROUPS; k++) begin : g_group
    cla_block #(
      .BLOCK_SIZE (BLOCK_SIZE)
    ) u_cla_block (
      .g        (bit_gen[k*BLOCK_SIZE +: BLOCK_SIZE]),
      .p        (bit_prop[k*BLOCK_SIZE +: BLOCK_SIZE]),
      .cin      (grp_carry[k]),
      .carry    (bit_carry[k*BLOCK_SIZE +: BLOCK_SIZE]),
      .grp_gen  (grp_gen[k]),
      .grp_prop (grp_prop[k])
    );

    assign grp_carry[k+1] = grp_gen[k] | (grp_prop[k] & grp_carry[k]);
  end

  assign sum_d = bit_prop ^ bit_carry;
  assign cf_d  = grp_carry[NUM_GROUPS];
  // Overflow: carry into the sign bit disagrees with carry out of it.
  assign of_d  = grp_carry[NUM_GROUPS] ^ bit_carry[DATA_WIDTH-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      S  <= '0;
      CF <= 1'b0;
      OF <= 1'b0;
    end else begin
      S  <= sum_d;
      CF <= cf_d;
      OF <= of_d;
    end
  end

endmodule : carry_lookahead_adder_sync

// File: tb/tb_carry_lookahead_adder_sync.sv
// Directed-vector bench for the default 16-bit adder plus a random sweep over
// widths 8/16/32 and group sizes 1..16, each against a 1-cycle-delayed reference.
module tb_carry_lookahead_adder_sync;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Default-parameter DUT used for the directed vectors.
  logic        rst;
  logic [15:0] a, b;
  logic        cin;
  logic [15:0] s;
  logic        cf, of;

  carry_lookahead_adder_sync u_dut (
    .clk (clk),
    .rst (rst),
    .A   (a),
    .B   (b),
    .Cin (cin),
    .S   (s),
    .CF  (cf),
    .OF  (of)
  );

  // Shared stimulus for the parameter sweep instances.
  logic        sw_rst = 1'b1;
  logic [31:0] sw_a = '0, sw_b = '0;
  logic        sw_cin = 1'b0;
  logic        sw_chk = 1'b0;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dw
    for (genvar gj = 0; gj < 5; gj++) begin : g_bs
      localparam int DW = 8 << gi;
      localparam int BS = 1 << gj;
      if (BS <= DW) begin : g_cfg
        logic [DW-1:0] s_o;
        logic          cf_o, of_o;
        logic [DW-1:0] exp_s;
        logic          exp_cf, exp_of;
        logic [DW:0]   sum_w;

        carry_lookahead_adder_sync #(
          .DATA_WIDTH (DW),
          .BLOCK_SIZE (BS)
        ) u_sweep (
          .clk (clk),
          .rst (sw_rst),
          .A   (sw_a[DW-1:0]),
          .B   (sw_b[DW-1:0]),
          .Cin (sw_cin),
          .S   (s_o),
          .CF  (cf_o),
          .OF  (of_o)
        );

        assign sum_w = {1'b0, sw_a[DW-1:0]} + {1'b0, sw_b[DW-1:0]} + {{DW{1'b0}}, sw_cin};

        // Reference register: same edge, same reset priority as the DUT.
        always @(posedge clk) begin
          if (sw_rst) begin
            exp_s  <= '0;
            exp_cf <= 1'b0;
            exp_of <= 1'b0;
          end else begin
            exp_s  <= sum_w[DW-1:0];
            exp_cf <= sum_w[DW];
            exp_of <= (sw_a[DW-1] == sw_b[DW-1]) && (sum_w[DW-1] != sw_a[DW-1]);
          end
        end

        always @(negedge clk) begin
          if (sw_chk) begin
            checks++;
            if ({s_o, cf_o, of_o} !== {exp_s, exp_cf, exp_of}) begin
              errors++;
              $display("FAIL sweep DW=%0d BS=%0d: got S=%h CF=%b OF=%b, expected S=%h CF=%b OF=%b",
                       DW, BS, s_o, cf_o, of_o, exp_s, exp_cf, exp_of);
            end
          end
        end
      end
    end
  end

  typedef struct {
    string       name;
    logic [15:0] va, vb;
    logic        vcin;
    logic [15:0] es;
    logic        ecf, eof;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [15:0] es, input logic ecf, input logic eof);
    checks++;
    if ({s, cf, of} !== {es, ecf, eof}) begin
      errors++;
      $display("FAIL %s: got S=%h CF=%b OF=%b, expected S=%h CF=%b OF=%b",
               name, s, cf, of, es, ecf, eof);
    end
  endtask

  // Drive one vector at the falling edge, then land #1 after the next rising edge.
  task automatic step(input logic [15:0] va, input logic [15:0] vb, input logic vcin, input logic vrst);
    @(negedge clk);
    a   = va;
    b   = vb;
    cin = vcin;
    rst = vrst;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{"carry_no_ovf_1", 16'hF077, 16'h7777, 1'b0, 16'h67EE, 1'b1, 1'b0};
    vecs[1]  = '{"carry_no_ovf_2", 16'hF997, 16'h1111, 1'b0, 16'h0AA8, 1'b1, 1'b0};
    vecs[2]  = '{"pos_overflow",   16'h6077, 16'h6753, 1'b0, 16'hC7CA, 1'b0, 1'b1};
    vecs[3]  = '{"neg_ovf_carry",  16'h8AA7, 16'h8111, 1'b0, 16'h0BB8, 1'b1, 1'b1};
    vecs[4]  = '{"cin_full_width", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[5]  = '{"cin_to_sign",    16'h7FFF, 16'h0000, 1'b1, 16'h8000, 1'b0, 1'b1};
    vecs[6]  = '{"zero",           16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[7]  = '{"min_plus_min",   16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[8]  = '{"plain_with_cin", 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
    vecs[9]  = '{"all_ones",       16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1, 1'b0};
    vecs[10] = '{"max_max_cin",    16'h7FFF, 16'h7FFF, 1'b1, 16'hFFFF, 1'b0, 1'b1};
    vecs[11] = '{"min_minus_one",  16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};

    rst = 1'b1;
    a   = 16'hFFFF;
    b   = 16'hFFFF;
    cin = 1'b1;
    @(posedge clk);
    #1;
    sw_chk = 1'b1;

    // Reset held for two edges with all-ones inputs, then release.
    step(16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
    check("reset_cycle1", 16'h0000, 1'b0, 1'b0);
    step(16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
    check("reset_cycle2", 16'h0000, 1'b0, 1'b0);
    step(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    check("first_after_reset", 16'hFFFF, 1'b1, 1'b0);

    foreach (vecs[i]) begin
      step(vecs[i].va, vecs[i].vb, vecs[i].vcin, 1'b0);
      check(vecs[i].name, vecs[i].es, vecs[i].ecf, vecs[i].eof);
    end

    // Inputs changing between edges must not disturb the registered outputs.
    step(16'h6077, 16'h6753, 1'b0, 1'b0);
    a = 16'h0001;
    b = 16'h0002;
    cin = 1'b1;
    @(negedge clk);
    check("hold_between_edges", 16'hC7CA, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    check("after_next_edge", 16'h0004, 1'b0, 1'b0);

    // Mid-stream reset discards the in-flight result, then back-to-back resumes.
    step(16'h8AA7, 16'h8111, 1'b0, 1'b1);
    check("midstream_reset", 16'h0000, 1'b0, 1'b0);
    step(16'hF077, 16'h7777, 1'b0, 1'b0);
    check("resume_after_reset", 16'h67EE, 1'b1, 1'b0);
    step(16'h7FFF, 16'h0000, 1'b1, 1'b0);
    check("back_to_back", 16'h8000, 1'b0, 1'b1);

    // Random back-to-back sweep across all parameter combinations.
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      sw_a   = $urandom;
      sw_b   = $urandom;
      sw_cin = 1'($urandom_range(0, 1));
      sw_rst = (i >= 150 && i < 152);
      // A few corner operands mixed into the stream.
      if (i % 37 == 5) begin
        sw_a = 32'hFFFF_FFFF;
        sw_b = 32'h0000_0000;
        sw_cin = 1'b1;
      end
      if (i % 41 == 7) begin
        sw_a = 32'h8080_8080;
        sw_b = 32'h8080_8080;
      end
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    sw_chk = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_carry_lookahead_adder_sync
